// File: rtl/hpi_reset_pkg.sv
// Shared definitions for the USB HPI reset controller: FSM encoding,
// default timing parameters and a constant-evaluable ceil(log2) helper.
package hpi_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RECOVER = 2'd2,
    ST_READY   = 2'd3
  } state_e;

  localparam int DEF_N_BTN      = 1;
  localparam int DEF_DEB_CYCLES = 50000;
  localparam int DEF_RST_CYCLES = 1000;
  localparam int DEF_REC_CYCLES = 5000;

  // Smallest r with 2**r >= value; usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: two-flop synchroniser followed by a
// stable-count debouncer that restarts on any sample matching the current level.
module btn_debounce
  import hpi_reset_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (clog2(DEB_CYCLES + 1) < 1) ? 1 : clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hpi_reset_ctl.sv
// Sequences the active-low reset of the USB controller HPI from power-on,
// debounced push-buttons and a software request, then signals readiness.
module hpi_reset_ctl
  import hpi_reset_pkg::*;
#(
  parameter int N_BTN      = DEF_N_BTN,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int REC_CYCLES = DEF_REC_CYCLES
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_BTN-1:0] btn,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic             usb_hpi_reset_n,
  output logic             ready,
  output logic             GLED,
  output logic             RLED,
  output logic             TLED,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ASSERT  = ST_ASSERT;
  localparam logic [1:0] HOLD    = ST_HOLD;
  localparam logic [1:0] RECOVER = ST_RECOVER;
  localparam logic [1:0] READY   = ST_READY;

  localparam int CNT_MAX = (RST_CYCLES > REC_CYCLES) ? RST_CYCLES : REC_CYCLES;
  localparam int CW      = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);

  logic [N_BTN-1:0] deb;
  logic [N_BTN-1:0] deb_q;
  logic             btn_any;
  logic             btn_rise;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             ack_nxt;
  logic             out_of_reset;

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .raw   (btn[i]),
      .level (deb[i])
    );
  end

  assign btn_any   = |deb;
  assign btn_rise  = |(deb & ~deb_q);
  assign state_dbg = state;

  // sw_rst_req is a level held by software until sw_rst_ack is seen; the
  // ack is a single-cycle pulse issued only when READY accepts the request,
  // so a request raised in any other state simply waits for READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '1) ? cnt : cnt + CW'(1);
    ack_nxt   = 1'b0;
    case (state)
      ASSERT: begin
        if (cnt >= CW'(RST_CYCLES - 1)) state_nxt = btn_any ? HOLD : RECOVER;
      end
      HOLD: begin
        if (!btn_any) state_nxt = RECOVER;
      end
      RECOVER: begin
        if (btn_rise) state_nxt = ASSERT;
        else if (cnt >= CW'(REC_CYCLES - 1)) state_nxt = READY;
      end
      READY: begin
        if (btn_rise || sw_rst_req) begin
          state_nxt = ASSERT;
          ack_nxt   = sw_rst_req;
        end
      end
      default: state_nxt = ASSERT;
    endcase
    if ((state_nxt != state) || (state == HOLD) || (state == READY)) cnt_nxt = '0;
  end

  // Outputs are registered from the next state so they switch on the same
  // edge as the state itself.
  assign out_of_reset = (state_nxt == RECOVER) || (state_nxt == READY);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= ASSERT;
      cnt             <= '0;
      deb_q           <= '0;
      sw_rst_ack      <= 1'b0;
      usb_hpi_reset_n <= 1'b0;
      ready           <= 1'b0;
      GLED            <= 1'b1;
      RLED            <= 1'b0;
      TLED            <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      deb_q           <= deb;
      sw_rst_ack      <= ack_nxt;
      usb_hpi_reset_n <= out_of_reset;
      ready           <= (state_nxt == READY);
      GLED            <= !out_of_reset;
      RLED            <= btn_any;
      TLED            <= (state_nxt == READY);
    end
  end

endmodule
